// File: rtl/vec_lsu_seq.sv
// Vector load/store sequencer: splits one LANES-element access into LANES/BEAT
// memory beats over a valid/ready port and reassembles load beats into a vector.
module vec_lsu_seq #(
    parameter int LANES = 16,
    parameter int N     = 16,
    parameter int BEAT  = 4,
    parameter int AW    = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_write_i,
    input  logic [AW-1:0]        req_addr_i,
    input  logic [LANES*N-1:0]   req_wdata_i,
    output logic                 mem_valid_o,
    input  logic                 mem_ready_i,
    output logic                 mem_write_o,
    output logic [AW-1:0]        mem_addr_o,
    output logic [BEAT*N-1:0]    mem_wdata_o,
    input  logic                 mem_rvalid_i,
    input  logic [BEAT*N-1:0]    mem_rdata_i,
    output logic                 resp_valid_o,
    output logic [LANES*N-1:0]   resp_rdata_o,
    output logic                 busy_o
);
    localparam int NB = LANES / BEAT;
    localparam int BW = $clog2(NB) + 1;

    if ((LANES % BEAT) != 0) begin : g_beat_chk
        $error("vec_lsu_seq: LANES must be a multiple of BEAT");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAITR, DONE} state_e;

    state_e               state_q, state_d;
    logic [BW-1:0]        beat_q, beat_d;
    logic                 write_q;
    logic [AW-1:0]        addr_q;
    logic [LANES*N-1:0]   wdata_q;
    logic [LANES*N-1:0]   asm_q, asm_d;
    logic [LANES*N-1:0]   rdata_q, rdata_d;
    logic                 last_beat;

    assign last_beat    = (beat_q == BW'(NB - 1));
    assign resp_rdata_o = rdata_q;

    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        asm_d        = asm_q;
        rdata_d      = rdata_q;
        req_ready_o  = 1'b0;
        busy_o       = 1'b1;
        mem_valid_o  = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_wdata_o  = '0;
        resp_valid_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                busy_o      = 1'b0;
                if (req_valid_i) begin
                    state_d = ISSUE;
                    beat_d  = '0;
                end
            end
            ISSUE: begin
                mem_valid_o = 1'b1;
                mem_write_o = write_q;
                mem_addr_o  = addr_q + AW'(beat_q) * AW'(BEAT);
                for (int b = 0; b < NB; b++) begin
                    if (beat_q == BW'(b)) mem_wdata_o = wdata_q[b*BEAT*N +: BEAT*N];
                end
                if (mem_ready_i) begin
                    if (!write_q) begin
                        state_d = WAITR;
                    end else begin
                        beat_d = beat_q + BW'(1);
                        if (last_beat) state_d = DONE;
                    end
                end
            end
            WAITR: begin
                if (mem_rvalid_i) begin
                    for (int b = 0; b < NB; b++) begin
                        if (beat_q == BW'(b)) asm_d[b*BEAT*N +: BEAT*N] = mem_rdata_i;
                    end
                    beat_d = beat_q + BW'(1);
                    // Publish the whole vector only once the final beat lands, so
                    // resp_rdata never shows a partially assembled load.
                    if (last_beat) begin
                        state_d = DONE;
                        rdata_d = asm_d;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            DONE: begin
                resp_valid_o = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            beat_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (state_q == IDLE && req_valid_i) begin
            write_q <= req_write_i;
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
        end
        asm_q <= asm_d;
    end

endmodule

// File: tb/tb_vec_lsu_seq.sv
// Randomised bench for vec_lsu_seq: three instances (BEAT=4/16/1) share stimulus,
// a behavioural memory model answers load beats and expectations come from the access rules.
`timescale 1ns/1ps
module tb_vec_lsu_seq;
    localparam int LANES = 16;
    localparam int N     = 16;
    localparam int AW    = 32;
    localparam int W     = LANES * N;

    logic clk = 1'b0;
    logic rst_n;
    logic [1:0] sel;
    logic req_valid, req_write, mem_ready, mem_rvalid;
    logic [AW-1:0] req_addr;
    logic [W-1:0] req_wdata, mem_rdata;

    logic rv [3];
    logic rr [3];
    logic mv [3];
    logic mw [3];
    logic rsv [3];
    logic bz [3];
    logic [AW-1:0] ma [3];
    logic [W-1:0] rd [3];
    logic [4*N-1:0]  wd0;
    logic [16*N-1:0] wd1;
    logic [N-1:0]    wd2;

    logic c_rr, c_mv, c_mw, c_rsv, c_bz;
    logic [AW-1:0] c_ma;
    logic [W-1:0] c_wd, c_rd;

    int n_run, n_fail;
    logic [AW-1:0] ob_addr [$];
    logic [W-1:0]  ob_wd [$];
    logic          ob_wr [$];
    int d_lat, d_rdy_busy, d_busy_low, d_unstable, d_rcvd;
    logic d_timeout, d_after, d_rdy_after;

    always #5 clk = ~clk;

    always_comb for (int k = 0; k < 3; k++) rv[k] = req_valid && (sel == 2'(k));

    vec_lsu_seq #(.LANES(LANES), .N(N), .BEAT(4), .AW(AW)) u_b4 (
        .clk_i(clk), .rst_ni(rst_n), .req_valid_i(rv[0]), .req_ready_o(rr[0]),
        .req_write_i(req_write), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .mem_valid_o(mv[0]), .mem_ready_i(mem_ready), .mem_write_o(mw[0]), .mem_addr_o(ma[0]),
        .mem_wdata_o(wd0), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata[4*N-1:0]),
        .resp_valid_o(rsv[0]), .resp_rdata_o(rd[0]), .busy_o(bz[0]));

    vec_lsu_seq #(.LANES(LANES), .N(N), .BEAT(16), .AW(AW)) u_b16 (
        .clk_i(clk), .rst_ni(rst_n), .req_valid_i(rv[1]), .req_ready_o(rr[1]),
        .req_write_i(req_write), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .mem_valid_o(mv[1]), .mem_ready_i(mem_ready), .mem_write_o(mw[1]), .mem_addr_o(ma[1]),
        .mem_wdata_o(wd1), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
        .resp_valid_o(rsv[1]), .resp_rdata_o(rd[1]), .busy_o(bz[1]));

    vec_lsu_seq #(.LANES(LANES), .N(N), .BEAT(1), .AW(AW)) u_b1 (
        .clk_i(clk), .rst_ni(rst_n), .req_valid_i(rv[2]), .req_ready_o(rr[2]),
        .req_write_i(req_write), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .mem_valid_o(mv[2]), .mem_ready_i(mem_ready), .mem_write_o(mw[2]), .mem_addr_o(ma[2]),
        .mem_wdata_o(wd2), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata[N-1:0]),
        .resp_valid_o(rsv[2]), .resp_rdata_o(rd[2]), .busy_o(bz[2]));

    always_comb begin
        c_rr  = rr[sel];
        c_mv  = mv[sel];
        c_mw  = mw[sel];
        c_rsv = rsv[sel];
        c_bz  = bz[sel];
        c_ma  = ma[sel];
        c_rd  = rd[sel];
        case (sel)
            2'd0:    c_wd = W'(wd0);
            2'd1:    c_wd = wd1;
            default: c_wd = W'(wd2);
        endcase
    end

    function automatic int beat_of(input logic [1:0] s);
        return (s == 2'd0) ? 4 : ((s == 2'd1) ? 16 : 1);
    endfunction

    // Memory contents: the element at address a holds a + 0x20.
    function automatic logic [N-1:0] memf(input logic [AW-1:0] a);
        return N'(a + 32'h20);
    endfunction

    function automatic logic [W-1:0] words_at(input logic [AW-1:0] a, input int cnt);
        logic [W-1:0] v;
        v = '0;
        for (int j = 0; j < cnt; j++) v[j*N +: N] = memf(a + AW'(j));
        return v;
    endfunction

    function automatic logic [W-1:0] store_beat(input logic [W-1:0] wd, input int b, input int bw);
        logic [W-1:0] v;
        v = '0;
        for (int j = 0; j < bw; j++) v[j*N +: N] = wd[(b*bw + j)*N +: N];
        return v;
    endfunction

    // Runs one access on the selected instance from a negedge; records beats and timing.
    task automatic drive(input logic wr, input logic [AW-1:0] addr, input logic [W-1:0] wdata,
                         input int rdelay, input int stall_beat, input int stall_len,
                         input logic spurious, input logic hold_next,
                         input logic [AW-1:0] nxt_addr, input int abort_at);
        int nbt, idx, beat, rwait, stall, guard;
        logic done, held;
        logic [AW-1:0] la, ha;
        logic [W-1:0] hd;
        nbt = beat_of(sel);
        ob_addr.delete(); ob_wd.delete(); ob_wr.delete();
        d_lat = 0; d_rdy_busy = 0; d_busy_low = 0; d_unstable = 0; d_rcvd = 0;
        d_timeout = 1'b0; d_after = 1'b0; d_rdy_after = 1'b0;
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        guard = 0;
        while (!c_rr && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!c_rr) begin
            d_timeout = 1'b1;
            req_valid = 1'b0;
            return;
        end
        @(negedge clk);
        if (hold_next) begin
            req_write = 1'b0;
            req_addr  = nxt_addr;
        end else begin
            req_valid = 1'b0;
        end
        idx = 2; beat = 0; rwait = -1; stall = 0; done = 1'b0; held = 1'b0;
        la = '0; ha = '0; hd = '0;
        while (!done) begin
            mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
            if (c_rr) d_rdy_busy++;
            if (!c_bz) d_busy_low++;
            if (c_rsv) begin
                d_lat = idx;
                done  = 1'b1;
            end else if (abort_at >= 0 && rwait >= 0 && d_rcvd == abort_at) begin
                done = 1'b1;
            end else if (c_mv) begin
                if (held && (c_ma !== ha || c_wd !== hd)) d_unstable++;
                ha = c_ma; hd = c_wd; held = 1'b0;
                if (spurious) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = ~words_at(c_ma, nbt);
                end
                if (beat == stall_beat && stall < stall_len) begin
                    stall++;
                    held = 1'b1;
                end else begin
                    mem_ready = 1'b1;
                    ob_addr.push_back(c_ma); ob_wd.push_back(c_wd); ob_wr.push_back(c_mw);
                    la = c_ma;
                    if (!c_mw) rwait = rdelay;
                    beat++;
                end
            end else if (rwait >= 0) begin
                if (rwait == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = words_at(la, nbt);
                    d_rcvd++;
                    rwait = -1;
                end else begin
                    rwait--;
                end
            end
            if (!done) begin
                @(negedge clk);
                idx++;
                if (idx > 400) begin
                    d_timeout = 1'b1;
                    done = 1'b1;
                end
            end
        end
        if (d_lat > 0) begin
            @(negedge clk);
            d_after = c_rsv;
            d_rdy_after = c_rr;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sel = 2'd0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            sel = 2'(k);
            #1;
            n_run++;
            if ({c_rr, c_mv, c_mw, c_rsv, c_bz} !== 5'b10000) begin
                n_fail++;
                $display("FAIL reset_ctrl[%0d]: got rdy,mv,mw,rsv,busy=%b want 10000", k, {c_rr, c_mv, c_mw, c_rsv, c_bz});
            end
            n_run++;
            if (c_ma !== '0 || c_wd !== '0 || c_rd !== '0) begin
                n_fail++;
                $display("FAIL reset_data[%0d]: got addr=%h wdata=%h rdata=%h want all 0", k, c_ma, c_wd, c_rd);
            end
        end
        sel = 2'd0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_store(input logic [1:0] s, input logic [AW-1:0] addr, input logic [W-1:0] wd,
                              input int stall_beat, input int stall_len, input string tag);
        int bw, nb, exp_lat;
        sel = s; bw = beat_of(s); nb = LANES / bw;
        exp_lat = 2 + nb + ((stall_beat >= 0 && stall_beat < nb) ? stall_len : 0);
        drive(1'b1, addr, wd, 0, stall_beat, stall_len, 1'b0, 1'b0, '0, -1);
        n_run++;
        if (d_timeout !== 1'b0 || ob_addr.size() != nb) begin
            n_fail++;
            $display("FAIL %s beats: got timeout=%0b beats=%0d want timeout=0 beats=%0d", tag, d_timeout, ob_addr.size(), nb);
        end
        for (int b = 0; b < nb && b < ob_addr.size(); b++) begin
            n_run++;
            if (ob_addr[b] !== addr + AW'(b*bw) || ob_wd[b] !== store_beat(wd, b, bw) || ob_wr[b] !== 1'b1) begin
                n_fail++;
                $display("FAIL %s beat%0d: got addr=%h data=%h wr=%b want addr=%h data=%h wr=1",
                         tag, b, ob_addr[b], ob_wd[b], ob_wr[b], addr + AW'(b*bw), store_beat(wd, b, bw));
            end
        end
        n_run++;
        if (d_lat != exp_lat || d_after !== 1'b0 || d_rdy_after !== 1'b1) begin
            n_fail++;
            $display("FAIL %s timing: got lat=%0d rsv_after=%b rdy_after=%b want lat=%0d 0 1", tag, d_lat, d_after, d_rdy_after, exp_lat);
        end
        n_run++;
        if (d_rdy_busy != 0 || d_busy_low != 0 || d_unstable != 0) begin
            n_fail++;
            $display("FAIL %s busy: got rdy_busy=%0d busy_low=%0d unstable=%0d want 0 0 0", tag, d_rdy_busy, d_busy_low, d_unstable);
        end
    endtask

    task automatic test_load(input logic [1:0] s, input logic [AW-1:0] addr, input int rdelay,
                             input logic spurious, input string tag);
        int bw, nb, exp_lat;
        sel = s; bw = beat_of(s); nb = LANES / bw;
        exp_lat = 2 + nb * (2 + rdelay);
        drive(1'b0, addr, '0, rdelay, -1, 0, spurious, 1'b0, '0, -1);
        n_run++;
        if (d_timeout !== 1'b0 || ob_addr.size() != nb) begin
            n_fail++;
            $display("FAIL %s beats: got timeout=%0b beats=%0d want timeout=0 beats=%0d", tag, d_timeout, ob_addr.size(), nb);
        end
        for (int b = 0; b < nb && b < ob_addr.size(); b++) begin
            n_run++;
            if (ob_addr[b] !== addr + AW'(b*bw) || ob_wr[b] !== 1'b0) begin
                n_fail++;
                $display("FAIL %s beat%0d: got addr=%h wr=%b want addr=%h wr=0", tag, b, ob_addr[b], ob_wr[b], addr + AW'(b*bw));
            end
        end
        n_run++;
        if (c_rd !== words_at(addr, LANES)) begin
            n_fail++;
            $display("FAIL %s rdata: got %h want %h", tag, c_rd, words_at(addr, LANES));
        end
        n_run++;
        if (d_lat != exp_lat || d_after !== 1'b0 || d_rdy_after !== 1'b1) begin
            n_fail++;
            $display("FAIL %s timing: got lat=%0d rsv_after=%b rdy_after=%b want lat=%0d 0 1", tag, d_lat, d_after, d_rdy_after, exp_lat);
        end
        n_run++;
        if (d_rdy_busy != 0 || d_busy_low != 0) begin
            n_fail++;
            $display("FAIL %s busy: got rdy_busy=%0d busy_low=%0d want 0 0", tag, d_rdy_busy, d_busy_low);
        end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] a1, a2;
        a1 = $urandom; a2 = $urandom;
        sel = 2'd0;
        drive(1'b0, a1, '0, 0, -1, 0, 1'b1, 1'b1, a2, -1);
        n_run++;
        if (c_rd !== words_at(a1, LANES)) begin
            n_fail++;
            $display("FAIL b2b_spurious rdata: got %h want %h", c_rd, words_at(a1, LANES));
        end
        n_run++;
        if (d_rdy_busy != 0 || ob_addr.size() != 4 || d_lat != 10) begin
            n_fail++;
            $display("FAIL b2b_first: got rdy_busy=%0d beats=%0d lat=%0d want 0 4 10", d_rdy_busy, ob_addr.size(), d_lat);
        end
        test_load(2'd0, a2, 1, 1'b0, "b2b_second");
    endtask

    task automatic test_sweep();
        logic [W-1:0] wd;
        for (int j = 0; j < W/32; j++) wd[j*32 +: 32] = $urandom;
        test_store(2'd1, $urandom, wd, -1, 0, "b16_store");
        test_load(2'd1, 32'hFFFF_FFFE, 0, 1'b0, "b16_load_wrap");
        test_store(2'd2, 32'hFFFF_FFF8, wd, 3, 2, "b1_store_wrap");
        test_load(2'd2, 32'hFFFF_FFFE, 1, 1'b1, "b1_load_wrap");
        test_load(2'd0, 32'hFFFF_FFFE, 0, 1'b0, "b4_load_wrap");
    endtask

    task automatic test_reset_midload();
        logic [AW-1:0] a;
        int pulses;
        a = $urandom; sel = 2'd0;
        drive(1'b0, a, '0, 0, -1, 0, 1'b0, 1'b0, '0, -1);
        n_run++;
        if (c_rd !== words_at(a, LANES)) begin
            n_fail++;
            $display("FAIL midload_prior rdata: got %h want %h", c_rd, words_at(a, LANES));
        end
        drive(1'b0, a + 32'h40, '0, 1, -1, 0, 1'b0, 1'b0, '0, 2);
        n_run++;
        if ({c_bz, c_mv, c_rsv} !== 3'b100 || ob_addr.size() != 3) begin
            n_fail++;
            $display("FAIL midload_waitr: got busy,mv,rsv=%b beats=%0d want 100 beats=3", {c_bz, c_mv, c_rsv}, ob_addr.size());
        end
        #2 rst_n = 1'b0;
        #1;
        n_run++;
        if ({c_rr, c_mv, c_bz, c_rsv} !== 4'b1000) begin
            n_fail++;
            $display("FAIL midload_async_ctrl: got rdy,mv,busy,rsv=%b want 1000", {c_rr, c_mv, c_bz, c_rsv});
        end
        n_run++;
        if (c_rd !== '0) begin
            n_fail++;
            $display("FAIL midload_async_rdata: got %h want 0", c_rd);
        end
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (c_rsv) pulses++;
        end
        n_run++;
        if (pulses != 0 || c_rr !== 1'b1 || c_rd !== '0) begin
            n_fail++;
            $display("FAIL midload_after: got pulses=%0d rdy=%b rdata=%h want 0 1 0", pulses, c_rr, c_rd);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] wd;
        logic [1:0] s;
        int nb;
        repeat (10) begin
            s  = 2'($urandom_range(0, 2));
            nb = LANES / beat_of(s);
            for (int j = 0; j < W/32; j++) wd[j*32 +: 32] = $urandom;
            if ($urandom_range(0, 1) == 1)
                test_store(s, $urandom, wd, $urandom_range(0, nb - 1), $urandom_range(0, 3), "rnd_store");
            else
                test_load(s, $urandom, $urandom_range(0, 3), 1'($urandom_range(0, 1)), "rnd_load");
        end
    endtask

    initial begin
        logic [W-1:0] ramp;
        n_run = 0; n_fail = 0;
        for (int i = 0; i < LANES; i++) ramp[i*N +: N] = N'(i);
        test_reset();
        test_store(2'd0, 32'h100, ramp, -1, 0, "store_zero_wait");
        test_load(2'd0, 32'h0, 3, 1'b0, "load_delay3");
        test_store(2'd0, 32'h100, ramp, 2, 5, "store_stall");
        test_back_to_back();
        test_sweep();
        test_reset_midload();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_run);
        $fatal(1, "watchdog");
    end

endmodule
